// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared 8-bit uio pin bus.
// A grant goes IDLE -> TURN (pins tri-stated) -> OWN (bounded burst) -> IDLE.
// Every change of owner passes through IDLE, so the pins always float for
// at least 1+TURNAROUND cycles between two drivers.
//
//   state | meaning
//   IDLE  | no owner, pins tri-stated, arbitrate when ena && |req
//   TURN  | owner chosen, pins still tri-stated for TURNAROUND cycles
//   OWN   | gnt[owner] high, one beat per cycle until last/limit/drop
module uio_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   wr_i,
  input  logic [NREQ*8-1:0] wdata_i,
  input  logic [NREQ-1:0]   last_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [7:0]        rdata_o,
  output logic              rvalid_o,
  output logic              busy_o,
  input  logic [7:0]        uio_in_i,
  output logic [7:0]        uio_out_o,
  output logic [7:0]        uio_oe_o
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [1:0]    TURN_LOAD = 2'(TURNAROUND);

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [1:0]      turn_q, turn_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic [OW-1:0]   scan_idx;
  logic [OW-1:0]   pick;
  logic            found;
  logic            own_req, own_wr, own_last;
  logic [7:0]      own_wdata;
  logic            own_exit;
  logic            read_beat;
  logic [OW-1:0]   rr_next;

  // Per-owner views of the request bundle.
  assign own_req   = req_i[owner_q];
  assign own_wr    = wr_i[owner_q];
  assign own_last  = last_i[owner_q];
  assign own_wdata = wdata_i[{owner_q, 3'b000} +: 8];
  assign own_exit  = own_last || (beat_q == BEAT_LAST) || !own_req;
  assign read_beat = (state_q == OWN) && own_req && !own_wr;
  assign rr_next   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = rr_ptr_q;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = OW'((int'(rr_ptr_q) + i) % NREQ);
      if (!found && req_i[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      turn_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      turn_q   <= turn_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next-state logic: arbitration, turnaround countdown, burst bookkeeping.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    turn_d   = turn_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (ena_i && found) begin
          owner_d = pick;
          if (TURNAROUND > 0) begin
            state_d = TURN;
            turn_d  = TURN_LOAD;
          end else begin
            state_d = OWN;
          end
        end
      end
      TURN: begin
        if (!ena_i) begin
          state_d = IDLE;
        end else if (turn_q <= 2'd1) begin
          state_d = OWN;
        end else begin
          turn_d = turn_q - 2'd1;
        end
      end
      OWN: begin
        if (read_beat) begin
          rdata_d  = uio_in_i;
          rvalid_d = 1'b1;
        end
        if (!ena_i || own_exit) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
          beat_d   = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant and pin drive come straight from state/owner, so an
  // async reset clears them without waiting for a clock.
  always_comb begin
    gnt_o     = '0;
    uio_oe_o  = 8'h00;
    uio_out_o = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = (state_q == OWN) && (owner_q == OW'(i));
    end
    if ((state_q == OWN) && own_req && own_wr) begin
      uio_oe_o  = 8'hFF;
      uio_out_o = own_wdata;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign busy_o   = (state_q != IDLE);

endmodule
